display_scheduler: RTL and testbench
====================================

Name: display_scheduler

Overview:
- Round-robin scheduler that shares the single 4-digit hex display between up to NUM_SRC requesters, e.g. PC, IR, ALU result and a debug register.
- Each requesting source owns the display for DWELL_CYCLES cycles, then ownership rotates.
- Output disp_data drives the 16-bit data input of the hex display block.
- Sits between the datapath debug taps and the display driver; runs on the same board clock.

Parameters:
- NUM_SRC, 4, number of requesters; legal range 2..8.
- DWELL_CYCLES, 1000, cycles a granted source is shown before rotation; must be >= 1.
- PTR_W, 2, width of the source index; must be >= clog2(NUM_SRC).

Ports:
- Interface: reset reset, asynchronous, active-high; clock in_clk.
- in_clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- src_req  input  NUM_SRC  per-source request; level-sensitive.
- src_data  input  16*NUM_SRC  source i value on bits [16*i+15:16*i].
- hold  input  1  freezes rotation while high; the current owner keeps the display.
- src_gnt  output  NUM_SRC  one-hot grant; all zero when nothing is granted.
- disp_data  output  16  value to display, registered.
- disp_src  output  PTR_W  index of the current owner.
- disp_blank  output  1  1 when no source is granted.

Behaviour:
- Reset values:
  - state = IDLE; src_gnt = 0; disp_data = 16'h0000; disp_src = 0; disp_blank = 1.
  - Dwell counter = 0; last-owner pointer = NUM_SRC-1, so the first search starts at index 0.
- Round-robin search: scan indices ptr+1, ptr+2, … modulo NUM_SRC, ending with ptr itself. The first index with src_req set wins.
- IDLE:
  - If any src_req bit is set, the next cycle enters SHOW with the search winner.
  - Set src_gnt[winner] = 1, disp_src = winner, disp_blank = 0; clear the counter.
  - Otherwise remain in IDLE.
- SHOW, owner cur:
  - disp_data <= src_data[cur] every cycle, so disp_data lags src_data by 1 cycle.
  - The counter increments each cycle while hold = 0. It holds its value while hold = 1.
- Rotation: when counter == DWELL_CYCLES-1 and hold = 0, run the search with ptr = cur.
  - If the winner differs from cur: the next cycle grants the winner and clears the counter.
  - If only cur is requesting: keep cur and wrap the counter to 0.
  - If there is no requester: go to IDLE.
- Owner drop: if src_req[cur] falls during SHOW, the next cycle re-runs the search from cur, even if hold = 1.
  - Grant the winner if one exists; otherwise go to IDLE.
  - Any re-grant clears the counter.
- IDLE entry: src_gnt = 0 and disp_blank = 1. disp_data and disp_src keep their last values.
- Grant latency: 1 cycle from a req rising in IDLE to src_gnt/disp_src updating. disp_data reflects the new owner 1 cycle after the grant.
- At most one src_gnt bit is ever high. Grant changes occur only on in_clk edges.
- Reset asserted mid-SHOW: all outputs return immediately (asynchronously) to the reset values.
- DWELL_CYCLES = 1: rotation is evaluated every cycle.

Optional Feature:
- Macro: DISP_SNAPSHOT_EN.
- Defined:
  - disp_data captures src_data[winner] only in the cycle the grant is issued, including a same-source re-grant after a dwell wrap.
  - The value is held for the whole dwell, so the display does not flicker while the datapath changes.
- Undefined: disp_data tracks src_data[cur] live every cycle, as described in Behaviour.

Test Plan:
- DWELL_CYCLES = 4, NUM_SRC = 4, reset released, src_req = 0 → disp_blank = 1, src_gnt = 0, disp_data = 0000.
- src_req = 4'b1111, src_data = {DDDD, CCCC, BBBB, AAAA} → grants 0, 1, 2, 3, 0 each lasting 4 cycles; disp_data AAAA, BBBB, CCCC, DDDD appears 1 cycle after each grant.
- Only src_req[2] = 1 for 12 cycles → src_gnt stays 4'b0100 with no gaps; the counter wraps 3 times.
- Owner 1 granted, src_req[1] falls in dwell cycle 1 while src_req[3] = 1 → next cycle src_gnt = 4'b1000 and the counter is 0. All requests low → IDLE, disp_blank = 1.
- hold = 1 for 10 cycles while owner 0 is shown with src_req = 4'b0011 → src_gnt stays 4'b0001. After hold falls, owner 0 finishes its remaining dwell, then rotates to 1.
- Reset pulsed mid-SHOW → outputs return to the reset values immediately. After release with src_req = 4'b1111, the first grant is index 0.
- With DISP_SNAPSHOT_EN: src_data[0] changes 1234 → 5678 mid-dwell → disp_data stays 1234 until the next grant.

Source files
------------

// File: rtl/display_scheduler_if.sv
// Display arbitration bus between the debug taps (master) and the round-robin scheduler (slave).
// Requests, source values and hold flow in; the one-hot grant and the registered display word flow out.
interface display_scheduler_if #(
  parameter int NUM_SRC = 4,
  parameter int PTR_W   = 2
);
  logic [NUM_SRC-1:0]    src_req;
  logic [16*NUM_SRC-1:0] src_data;
  logic                  hold;
  logic [NUM_SRC-1:0]    src_gnt;
  logic [15:0]           disp_data;
  logic [PTR_W-1:0]      disp_src;
  logic                  disp_blank;

  modport master (
    output src_req, src_data, hold,
    input  src_gnt, disp_data, disp_src, disp_blank
  );

  modport slave (
    input  src_req, src_data, hold,
    output src_gnt, disp_data, disp_src, disp_blank
  );
endinterface

// File: rtl/display_scheduler.sv
// Round-robin owner of the 4-digit hex display; each requester is shown for DWELL_CYCLES, hold freezes rotation.
// Latency: grant 1 cycle after a request; disp_data 1 cycle after grant (DISP_SNAPSHOT_EN: captured with the grant).
module display_scheduler #(
  parameter int NUM_SRC      = 4,
  parameter int DWELL_CYCLES = 1000,
  parameter int PTR_W        = 2
) (
  input  logic                in_clk,
  input  logic                reset,
  display_scheduler_if.slave  bus
);
  localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int IDX_W = $clog2(NUM_SRC);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [NUM_SRC-1:0] GNT_ONE  = NUM_SRC'(1);
  localparam logic [PTR_W-1:0]   PTR_INIT = PTR_W'(NUM_SRC - 1);

  typedef enum logic {IDLE, SHOW} state_t;

  state_t           state;
  logic [PTR_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;

  logic [15:0]      data_arr [NUM_SRC];
  logic             found;
  logic [PTR_W-1:0] winner;
  logic             do_search;
  int               idx;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      data_arr[i] = bus.src_data[16*i +: 16];
    end
  end

  // Scan from ptr+NUM_SRC down to ptr+1 so the last hit is the first index in round-robin order.
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    idx    = 0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (bus.src_req[IDX_W'(idx)]) begin
        found  = 1'b1;
        winner = PTR_W'(idx);
      end
    end
  end

  // ptr equals the current owner in SHOW; an owner drop forces a search even under hold.
  always_comb begin
    do_search = 1'b1;
    if (state == SHOW) begin
      do_search = !bus.src_req[IDX_W'(ptr)] || (!bus.hold && (cnt == CNT_LAST));
    end
  end

  always_ff @(posedge in_clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      ptr            <= PTR_INIT;
      cnt            <= '0;
      bus.src_gnt    <= '0;
      bus.disp_data  <= 16'h0000;
      bus.disp_src   <= '0;
      bus.disp_blank <= 1'b1;
    end else begin
`ifndef DISP_SNAPSHOT_EN
      if (state == SHOW) begin
        bus.disp_data <= data_arr[IDX_W'(ptr)];
      end
`endif
      if (do_search) begin
        if (found) begin
          state          <= SHOW;
          ptr            <= winner;
          cnt            <= '0;
          bus.src_gnt    <= GNT_ONE << winner;
          bus.disp_src   <= winner;
          bus.disp_blank <= 1'b0;
`ifdef DISP_SNAPSHOT_EN
          bus.disp_data  <= data_arr[IDX_W'(winner)];
`endif
        end else begin
          state          <= IDLE;
          bus.src_gnt    <= '0;
          bus.disp_blank <= 1'b1;
        end
      end else if (!bus.hold) begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_display_scheduler.sv
// Bench for display_scheduler: directed scenarios with constant expectations plus a randomized run
// checked against a cycle-level reference model of owner, dwell usage and display word.
module tb_display_scheduler;
  localparam int N  = 4;
  localparam int DW = 4;
  localparam int PW = 2;

  logic in_clk = 1'b0;
  logic reset;
  always #5 in_clk = ~in_clk;

  display_scheduler_if #(.NUM_SRC(N), .PTR_W(PW)) bus ();

  display_scheduler #(.NUM_SRC(N), .DWELL_CYCLES(DW), .PTR_W(PW)) dut (
    .in_clk (in_clk),
    .reset  (reset),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] dval [N];

  // Reference model state
  int          m_own;
  int          m_last;
  int          m_used;
  int          m_src;
  logic [15:0] m_data;

  task automatic drive_data();
    for (int i = 0; i < N; i++) bus.src_data[16*i +: 16] = dval[i];
  endtask

  task automatic tick();
    @(posedge in_clk);
    @(negedge in_clk);
  endtask

  task automatic do_reset();
    @(negedge in_clk);
    reset       = 1'b1;
    bus.src_req = '0;
    bus.hold    = 1'b0;
    for (int i = 0; i < N; i++) dval[i] = 16'h0000;
    drive_data();
    @(negedge in_clk);
    @(negedge in_clk);
    reset = 1'b0;
  endtask

  function automatic int rr_pick(int from, logic [N-1:0] req);
    logic [N-1:0] sh;
    for (int k = 1; k <= N; k++) begin
      sh = req >> ((from + k) % N);
      if (sh[0]) return (from + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [15:0] pattern(int i);
    return 16'hAAAA + 16'(i) * 16'h1111;
  endfunction

  task automatic model_reset();
    m_own  = -1;
    m_last = N - 1;
    m_used = 0;
    m_src  = 0;
    m_data = 16'h0000;
  endtask

  task automatic model_grant(int w);
    m_own  = w;
    m_last = w;
    m_used = 0;
    m_src  = w;
`ifdef DISP_SNAPSHOT_EN
    m_data = dval[w];
`endif
  endtask

  task automatic model_step(logic [N-1:0] req, logic hold);
    int w;
    logic [N-1:0] sh;
    if (m_own < 0) begin
      w = rr_pick(m_last, req);
      if (w >= 0) model_grant(w);
    end else begin
`ifndef DISP_SNAPSHOT_EN
      m_data = dval[m_own];
`endif
      sh = req >> m_own;
      if (!sh[0]) begin
        w = rr_pick(m_own, req);
        if (w >= 0) model_grant(w);
        else m_own = -1;
      end else if (!hold) begin
        m_used++;
        if (m_used == DW) model_grant(rr_pick(m_own, req));
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.disp_blank !== 1'b1) begin n_bad++; $display("FAIL reset_blank: got %b want 1", bus.disp_blank); end
    n_cmp++; if (bus.src_gnt !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt: got %b want 0000", bus.src_gnt); end
    n_cmp++; if (bus.disp_data !== 16'h0000) begin n_bad++; $display("FAIL reset_data: got %h want 0000", bus.disp_data); end
    n_cmp++; if (bus.disp_src !== 2'd0) begin n_bad++; $display("FAIL reset_src: got %0d want 0", bus.disp_src); end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++; if (bus.disp_blank !== 1'b1 || bus.src_gnt !== 4'b0000) begin
        n_bad++; $display("FAIL idle_stay: got blank=%b gnt=%b want 1/0000", bus.disp_blank, bus.src_gnt);
      end
    end
  endtask

  task automatic test_rotation();
    int own;
    logic [15:0] exp_d;
    do_reset();
    for (int i = 0; i < N; i++) dval[i] = pattern(i);
    drive_data();
    bus.src_req = 4'b1111;
    for (int c = 1; c <= 17; c++) begin
      tick();
      own = ((c - 1) / DW) % N;
      n_cmp++; if (bus.src_gnt !== 4'(1 << own) || bus.disp_src !== 2'(own)) begin
        n_bad++; $display("FAIL rot_gnt c=%0d: got gnt=%b src=%0d want owner %0d", c, bus.src_gnt, bus.disp_src, own);
      end
`ifdef DISP_SNAPSHOT_EN
      exp_d = pattern(own);
`else
      exp_d = (c >= 2) ? pattern(((c - 2) / DW) % N) : 16'h0000;
`endif
      n_cmp++; if (bus.disp_data !== exp_d) begin
        n_bad++; $display("FAIL rot_data c=%0d: got %h want %h", c, bus.disp_data, exp_d);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    bus.src_req = 4'b0100;
    for (int c = 1; c <= 13; c++) begin
      tick();
      n_cmp++; if (bus.src_gnt !== 4'b0100 || bus.disp_blank !== 1'b0) begin
        n_bad++; $display("FAIL single c=%0d: got gnt=%b blank=%b want 0100/0", c, bus.src_gnt, bus.disp_blank);
      end
    end
  endtask

  task automatic test_drop();
    do_reset();
    bus.src_req = 4'b0010;
    tick();
    n_cmp++; if (bus.src_gnt !== 4'b0010) begin n_bad++; $display("FAIL drop_first: got %b want 0010", bus.src_gnt); end
    bus.src_req = 4'b1010;
    tick();
    bus.src_req = 4'b1000;
    tick();
    n_cmp++; if (bus.src_gnt !== 4'b1000 || bus.disp_src !== 2'd3) begin
      n_bad++; $display("FAIL drop_regrant: got gnt=%b src=%0d want 1000/3", bus.src_gnt, bus.disp_src);
    end
    // A freshly cleared counter keeps owner 3 for a full dwell before handing back to 1.
    bus.src_req = 4'b1010;
    for (int c = 1; c <= DW; c++) begin
      tick();
      n_cmp++; if (bus.src_gnt !== ((c < DW) ? 4'b1000 : 4'b0010)) begin
        n_bad++; $display("FAIL drop_dwell c=%0d: got %b want %b", c, bus.src_gnt, (c < DW) ? 4'b1000 : 4'b0010);
      end
    end
    bus.src_req = 4'b0000;
    tick();
    n_cmp++; if (bus.disp_blank !== 1'b1 || bus.src_gnt !== 4'b0000 || bus.disp_src !== 2'd1) begin
      n_bad++; $display("FAIL drop_idle: got blank=%b gnt=%b src=%0d want 1/0000/1", bus.disp_blank, bus.src_gnt, bus.disp_src);
    end
  endtask

  task automatic test_hold();
    do_reset();
    bus.src_req = 4'b0011;
    tick();
    tick();
    bus.hold = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_cmp++; if (bus.src_gnt !== 4'b0001) begin n_bad++; $display("FAIL hold_freeze c=%0d: got %b want 0001", c, bus.src_gnt); end
    end
    bus.hold = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      n_cmp++; if (bus.src_gnt !== ((c < 3) ? 4'b0001 : 4'b0010)) begin
        n_bad++; $display("FAIL hold_resume c=%0d: got %b want %b", c, bus.src_gnt, (c < 3) ? 4'b0001 : 4'b0010);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < N; i++) dval[i] = pattern(i);
    drive_data();
    bus.src_req = 4'b1111;
    repeat (6) tick();
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.src_gnt !== 4'b0000 || bus.disp_blank !== 1'b1 || bus.disp_data !== 16'h0000 || bus.disp_src !== 2'd0) begin
      n_bad++; $display("FAIL mid_reset: got gnt=%b blank=%b data=%h src=%0d want 0000/1/0000/0",
                        bus.src_gnt, bus.disp_blank, bus.disp_data, bus.disp_src);
    end
    @(negedge in_clk);
    reset = 1'b0;
    tick();
    n_cmp++; if (bus.src_gnt !== 4'b0001 || bus.disp_src !== 2'd0) begin
      n_bad++; $display("FAIL mid_reset_first: got gnt=%b src=%0d want 0001/0", bus.src_gnt, bus.disp_src);
    end
  endtask

  task automatic test_snapshot();
    logic [15:0] exp_d;
    do_reset();
    dval[0] = 16'h1234;
    drive_data();
    bus.src_req = 4'b0001;
    tick();
    tick();
    dval[0] = 16'h5678;
    drive_data();
    for (int c = 3; c <= 5; c++) begin
      tick();
`ifdef DISP_SNAPSHOT_EN
      exp_d = (c < 5) ? 16'h1234 : 16'h5678;
`else
      exp_d = 16'h5678;
`endif
      n_cmp++; if (bus.disp_data !== exp_d) begin
        n_bad++; $display("FAIL snapshot c=%0d: got %h want %h", c, bus.disp_data, exp_d);
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] exp_gnt;
    do_reset();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) bus.src_req = N'($urandom_range(0, (1 << N) - 1));
      bus.hold = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < N; i++) dval[i] = 16'($urandom);
      drive_data();
      tick();
      model_step(bus.src_req, bus.hold);
      exp_gnt = (m_own < 0) ? '0 : N'(1 << m_own);
      n_cmp++; if (bus.src_gnt !== exp_gnt || bus.disp_blank !== (m_own < 0)) begin
        n_bad++; $display("FAIL rand_gnt c=%0d: got gnt=%b blank=%b want %b/%b", c, bus.src_gnt, bus.disp_blank, exp_gnt, m_own < 0);
      end
      n_cmp++; if (bus.disp_data !== m_data || bus.disp_src !== PW'(m_src)) begin
        n_bad++; $display("FAIL rand_disp c=%0d: got data=%h src=%0d want %h/%0d", c, bus.disp_data, bus.disp_src, m_data, m_src);
      end
    end
  endtask

  initial begin
    reset        = 1'b1;
    bus.src_req  = '0;
    bus.hold     = 1'b0;
    bus.src_data = '0;
    test_reset();
    test_rotation();
    test_single();
    test_drop();
    test_hold();
    test_reset_mid();
    test_snapshot();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
